phase_unwrapper: RTL and testbench

- Sits directly downstream of the CORDIC phase FSM.
- Consumes each wrapped phase sample (`phi`, range ±π) together with its one-cycle completion strobe.
- Emits a continuous, unwrapped phase. Each ±π crossing is tracked with a signed wrap counter.
- The result feeds the OPD/delay-line control loop, which needs a phase free of 2π discontinuities.

---
 rtl/phase_pkg.sv | 33 +++
 rtl/wrap_detect.sv | 36 +++
 rtl/phase_unwrapper.sv | 146 ++++++++++++++
 tb/tb_phase_unwrapper.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared constants and types for the phase-unwrapping path.
// Phase scale is 2^CORDIC_SCALE_BITS LSBs per radian, so PI_VAL and TWO_PI_VAL
// are pi and 2*pi in wrapped-phase LSBs.
package phase_pkg;

  localparam int CORDIC_SCALE_BITS = 23;
  localparam int PHI_WIDTH         = 26;
  localparam int PI_VAL            = 26353589;
  localparam int TWO_PI_VAL        = 52707178;

  // Encoded as the two's-complement value of the correction sign, so the
  // bits can be sign-extended straight into the wrap counter arithmetic.
  typedef enum logic [1:0] {
    WRAP_NONE = 2'b00,
    WRAP_POS  = 2'b01,
    WRAP_NEG  = 2'b11
  } wrap_dir_t;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_TRACK = 1'b1
  } unwrap_state_t;

  // Largest wrap count whose offset, plus a worst-case +/-pi sample, still
  // fits in a signed out_width-bit result.
  function automatic int wrap_limit(input int out_width, input int pi_val,
                                    input int two_pi_val);
    longint max_out;
    max_out = (longint'(1) <<< (out_width - 1)) - 1;
    return int'((max_out - longint'(pi_val)) / longint'(two_pi_val));
  endfunction

endpackage

// File: rtl/wrap_detect.sv
// Combinational wrap-direction classifier.
// Compares a wrapped phase sample against the previous one and reports which
// 2*pi correction keeps the phase continuous.
// Ports:
//   phi      - current wrapped phase (signed)
//   phi_prev - previous wrapped phase (signed)
//   dir      - WRAP_NEG if the step exceeds +pi, WRAP_POS if below -pi,
//              otherwise WRAP_NONE (a step of exactly +/-pi is not a wrap)
module wrap_detect
  import phase_pkg::*;
#(
  parameter int PHI_WIDTH = phase_pkg::PHI_WIDTH,
  parameter int PI_VAL    = phase_pkg::PI_VAL
) (
  input  logic signed [PHI_WIDTH-1:0] phi,
  input  logic signed [PHI_WIDTH-1:0] phi_prev,
  output wrap_dir_t                   dir
);

  localparam logic signed [PHI_WIDTH:0] PI_POS = (PHI_WIDTH+1)'(PI_VAL);
  localparam logic signed [PHI_WIDTH:0] PI_NEG = -PI_POS;

  logic signed [PHI_WIDTH:0] delta;

  // One extra bit makes the difference of two in-range samples exact.
  always_comb begin
    delta = {phi[PHI_WIDTH-1], phi} - {phi_prev[PHI_WIDTH-1], phi_prev};
    dir   = WRAP_NONE;
    if (delta > PI_POS) begin
      dir = WRAP_NEG;
    end else if (delta < PI_NEG) begin
      dir = WRAP_POS;
    end
  end

endmodule

// File: rtl/phase_unwrapper.sv
// Phase unwrapper: turns the wrapped CORDIC phase stream into a continuous
// phase by accumulating 2*pi corrections across +/-pi crossings.
// Ports:
//   clk_i, reset_i - clock and synchronous active-high reset
//   phi_i, valid_i - wrapped phase sample and its one-cycle strobe
//   clear_i        - resync: the next accepted sample restarts at offset 0
//   unwrapped_o    - unwrapped phase, valid_o strobes two cycles after valid_i
//   wrap_count_o   - signed net number of corrections applied
//   overflow_o     - sticky, set when a correction was suppressed at the limit
module phase_unwrapper
  import phase_pkg::*;
#(
  parameter int PHI_WIDTH  = phase_pkg::PHI_WIDTH,
  parameter int OUT_WIDTH  = 32,
  parameter int PI_VAL     = phase_pkg::PI_VAL,
  parameter int TWO_PI_VAL = phase_pkg::TWO_PI_VAL
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic signed [PHI_WIDTH-1:0] phi_i,
  input  logic                        valid_i,
  input  logic                        clear_i,
  output logic signed [OUT_WIDTH-1:0] unwrapped_o,
  output logic                        valid_o,
  output logic signed [7:0]           wrap_count_o,
  output logic                        overflow_o
);

  localparam int WRAP_LIMIT = wrap_limit(OUT_WIDTH, PI_VAL, TWO_PI_VAL);
  localparam logic signed [8:0] LIMIT_POS = 9'(WRAP_LIMIT);
  localparam logic signed [8:0] LIMIT_NEG = -LIMIT_POS;
  localparam logic signed [OUT_WIDTH-1:0] TWO_PI_OUT = OUT_WIDTH'(TWO_PI_VAL);

  unwrap_state_t state, state_next;

  logic signed [PHI_WIDTH-1:0] phi_prev;
  logic signed [PHI_WIDTH-1:0] phi_s1;
  wrap_dir_t                   dir_raw, sample_dir, dir_s1;
  logic                        valid_s1;

  logic signed [OUT_WIDTH-1:0] offset, offset_next, phi_ext;
  logic signed [7:0]           wrap_count, wrap_count_next;
  logic signed [8:0]           wrap_sum;
  logic                        wrap_fits, wrap_apply, wrap_suppress;

  wrap_detect #(
    .PHI_WIDTH(PHI_WIDTH),
    .PI_VAL   (PI_VAL)
  ) u_wrap_detect (
    .phi     (phi_i),
    .phi_prev(phi_prev),
    .dir     (dir_raw)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_FIRST;
    end else begin
      state <= state_next;
    end
  end

  // A sample arriving with clear_i is the new first sample, so it carries no
  // correction and still moves the FSM on to TRACK.
  always_comb begin
    state_next = state;
    sample_dir = WRAP_NONE;
    if (valid_i) begin
      state_next = ST_TRACK;
    end else if (clear_i) begin
      state_next = ST_FIRST;
    end
    if (state == ST_TRACK && !clear_i) begin
      sample_dir = dir_raw;
    end
  end

  // Stage 1: phi_prev follows every accepted sample immediately so that
  // back-to-back samples classify against the right predecessor.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_s1 <= 1'b0;
      phi_s1   <= '0;
      dir_s1   <= WRAP_NONE;
      phi_prev <= '0;
    end else begin
      valid_s1 <= valid_i;
      if (valid_i) begin
        phi_s1   <= phi_i;
        dir_s1   <= sample_dir;
        phi_prev <= phi_i;
      end
    end
  end

  // Stage 2 correction: a wrap that would push the count past the limit is
  // dropped, holding the offset so the output stays representable.
  always_comb begin
    wrap_sum        = {wrap_count[7], wrap_count} + {{7{dir_s1[1]}}, dir_s1};
    wrap_fits       = (wrap_sum <= LIMIT_POS) && (wrap_sum >= LIMIT_NEG);
    wrap_apply      = valid_s1 && (dir_s1 != WRAP_NONE) && wrap_fits;
    wrap_suppress   = valid_s1 && (dir_s1 != WRAP_NONE) && !wrap_fits;
    offset_next     = offset;
    wrap_count_next = wrap_count;
    if (wrap_apply) begin
      wrap_count_next = wrap_sum[7:0];
      if (dir_s1 == WRAP_POS) begin
        offset_next = offset + TWO_PI_OUT;
      end else begin
        offset_next = offset - TWO_PI_OUT;
      end
    end
    phi_ext = {{(OUT_WIDTH-PHI_WIDTH){phi_s1[PHI_WIDTH-1]}}, phi_s1};
  end

  // clear_i only resets the accumulator; the sample leaving stage 1 on that
  // same edge still uses the pre-clear offset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o     <= 1'b0;
      unwrapped_o <= '0;
      offset      <= '0;
      wrap_count  <= '0;
      overflow_o  <= 1'b0;
    end else begin
      valid_o <= valid_s1;
      if (valid_s1) begin
        unwrapped_o <= phi_ext + offset_next;
      end
      if (clear_i) begin
        offset     <= '0;
        wrap_count <= '0;
        overflow_o <= 1'b0;
      end else begin
        offset     <= offset_next;
        wrap_count <= wrap_count_next;
        if (wrap_suppress) begin
          overflow_o <= 1'b1;
        end
      end
    end
  end

  assign wrap_count_o = wrap_count;

endmodule

// File: tb/tb_phase_unwrapper.sv
// Self-checking bench for phase_unwrapper. Each driven sample is run through a
// small behavioural unwrapping model and the expected result is queued; the
// monitor pops and compares whenever valid_o fires.
module tb_phase_unwrapper;

  localparam int PI         = 26353589;
  localparam int TWO_PI     = 52707178;
  localparam int LIMIT      = 40;
  localparam int RAMP_STEP  = 20000000;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic signed [25:0]  phi_i;
  logic                valid_i;
  logic                clear_i;
  logic signed [31:0]  unwrapped_o;
  logic                valid_o;
  logic signed [7:0]   wrap_count_o;
  logic                overflow_o;

  phase_unwrapper dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .phi_i       (phi_i),
    .valid_i     (valid_i),
    .clear_i     (clear_i),
    .unwrapped_o (unwrapped_o),
    .valid_o     (valid_o),
    .wrap_count_o(wrap_count_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int cycle = 0;
  always @(posedge clk_i) cycle <= cycle + 1;

  typedef struct {
    longint unwrapped;
    int     wrap_count;
    bit     overflow;
    int     due;
  } exp_t;

  exp_t exp_q[$];

  int checks_total  = 0;
  int checks_passed = 0;

  bit     m_first;
  longint m_prev;
  longint m_offset;
  int     m_count;
  bit     m_ovf;

  bit     ramp_on   = 1'b0;
  bit     have_last = 1'b0;
  longint last_out  = 0;

  task automatic checkOutput(input string tag, input longint observed,
                             input longint expected);
    checks_total++;
    if (observed == expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int wrap_phase(input longint v);
    longint r;
    r = v % TWO_PI;
    if (r > PI) r -= TWO_PI;
    return int'(r);
  endfunction

  task automatic modelReset();
    m_first  = 1'b1;
    m_prev   = 0;
    m_offset = 0;
    m_count  = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Drives one sample for one cycle and queues what the unwrapped stream
  // must look like for it.
  task automatic applyStimulus(input int phi, input bit clr);
    longint delta;
    int     dir;
    exp_t   e;
    if (clr) begin
      m_first  = 1'b1;
      m_offset = 0;
      m_count  = 0;
      m_ovf    = 1'b0;
    end
    if (m_first) begin
      m_first = 1'b0;
    end else begin
      delta = longint'(phi) - m_prev;
      dir   = (delta > PI) ? -1 : ((delta < -PI) ? 1 : 0);
      if (dir != 0) begin
        if ((m_count + dir > LIMIT) || (m_count + dir < -LIMIT)) begin
          m_ovf = 1'b1;
        end else begin
          m_count  += dir;
          m_offset += longint'(dir) * TWO_PI;
        end
      end
    end
    m_prev       = phi;
    e.unwrapped  = longint'(phi) + m_offset;
    e.wrap_count = m_count;
    e.overflow   = m_ovf;
    e.due        = cycle + 2;
    exp_q.push_back(e);
    phi_i   = 26'(phi);
    valid_i = 1'b1;
    clear_i = clr;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (!reset_i && valid_o) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("unwrapped", unwrapped_o, e.unwrapped);
        checkOutput("wrap_count", wrap_count_o, e.wrap_count);
        checkOutput("overflow", overflow_o, e.overflow);
        checkOutput("latency", cycle, e.due);
        if (ramp_on && have_last && !overflow_o) begin
          checkOutput("ramp_step", unwrapped_o - last_out, RAMP_STEP);
        end
        last_out  = unwrapped_o;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    clear_i = 1'b0;
    phi_i   = '0;
    modelReset();
    idleCycles(3);
    checkOutput("reset_unwrapped", unwrapped_o, 0);
    checkOutput("reset_valid", valid_o, 0);
    checkOutput("reset_wrap_count", wrap_count_o, 0);
    checkOutput("reset_overflow", overflow_o, 0);
    reset_i = 1'b0;
    idleCycles(1);

    $display("[TB] small steps, no wrap");
    applyStimulus(0, 1'b0);
    idleCycles(1);
    applyStimulus(1000000, 1'b0);
    applyStimulus(2000000, 1'b0);
    idleCycles(4);
    checkOutput("steps_final", unwrapped_o, 2000000);

    $display("[TB] positive wrap");
    applyStimulus(25000000, 1'b1);
    applyStimulus(-25000000, 1'b0);
    idleCycles(4);
    checkOutput("pos_wrap_out", unwrapped_o, 27707178);
    checkOutput("pos_wrap_count", wrap_count_o, 1);

    $display("[TB] negative wrap");
    applyStimulus(-25000000, 1'b1);
    applyStimulus(25000000, 1'b0);
    idleCycles(4);
    checkOutput("neg_wrap_out", unwrapped_o, -27707178);
    checkOutput("neg_wrap_count", wrap_count_o, -1);

    $display("[TB] step of exactly pi");
    applyStimulus(0, 1'b1);
    applyStimulus(PI, 1'b0);
    applyStimulus(-PI, 1'b0);
    idleCycles(4);
    checkOutput("pi_step_out", unwrapped_o, PI);
    checkOutput("pi_step_count", wrap_count_o, 1);

    $display("[TB] ramp to saturation");
    ramp_on   = 1'b1;
    have_last = 1'b0;
    for (int k = 0; k < 200; k++) begin
      applyStimulus(wrap_phase(longint'(k) * RAMP_STEP), k == 0);
    end
    idleCycles(4);
    ramp_on = 1'b0;
    checkOutput("ramp_overflow", overflow_o, 1);
    checkOutput("ramp_wrap_count", wrap_count_o, LIMIT);

    $display("[TB] clear with coincident sample");
    applyStimulus(-1000, 1'b1);
    idleCycles(4);
    checkOutput("clear_out", unwrapped_o, -1000);
    checkOutput("clear_wrap_count", wrap_count_o, 0);
    checkOutput("clear_overflow", overflow_o, 0);

    $display("[TB] reset with sample in flight");
    phi_i   = 26'(25000000);
    valid_i = 1'b1;
    idleCycles(1);
    valid_i = 1'b0;
    reset_i = 1'b1;
    idleCycles(1);
    reset_i = 1'b0;
    modelReset();
    idleCycles(3);
    applyStimulus(-25000000, 1'b0);
    idleCycles(4);
    checkOutput("post_reset_out", unwrapped_o, -25000000);
    checkOutput("post_reset_count", wrap_count_o, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      idleCycles(1);
    end
    while (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      checkOutput("missing_valid", 0, 1);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
